// File: rtl/switch_lights_filtered.sv
// switch_lights_filtered
//
// Reads N_SW slide switches, synchronises and (optionally) debounces each
// one, and drives a registered light code: either the number of switches
// that are on (mode 0) or the 1-based index of the highest switch that is
// on (mode 1). A one-cycle `changed` strobe follows every update of
// `lights`.
//
// Build option: define SWITCH_DEBOUNCE_EN to include the per-switch
// debounce filters. Without it the synchronised levels feed the code
// logic directly, `stable` is tied high and DB_CYCLES has no effect.
//
// Parameters:
//   N_SW       number of switches, 1..16
//   DB_CYCLES  consecutive stable cycles needed to accept an edge, >= 2
//   CNT_W      derived width of `lights`, clog2(N_SW+1)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   switches  in   raw asynchronous switch levels [N_SW]
//   mode      in   0 = popcount, 1 = priority index
//   lights    out  registered light code [CNT_W]
//   changed   out  high for one cycle after `lights` takes a new value
//   stable    out  high when no switch has a pending, unaccepted transition
//
// There is no handshake on this block: inputs are levels sampled every
// cycle and outputs are registered levels plus the `changed` strobe.
module switch_lights_filtered #(
  parameter int N_SW      = 4,
  parameter int DB_CYCLES = 16,
  localparam int CNT_W    = $clog2(N_SW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SW-1:0]  switches,
  input  logic             mode,
  output logic [CNT_W-1:0] lights,
  output logic             changed,
  output logic             stable
);

  // Elaboration-time guard on the parameter ranges.
  if (N_SW < 1 || N_SW > 16) begin : g_bad_n_sw
    $error("switch_lights_filtered: N_SW must be in 1..16");
  end
  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("switch_lights_filtered: DB_CYCLES must be at least 2");
  end

  // Two-flop synchroniser for the asynchronous switch pins.
  logic [N_SW-1:0] s1;
  logic [N_SW-1:0] s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= switches;
      s2 <= s1;
    end
  end

  // Filtered switch vector that drives the light code.
  logic [N_SW-1:0] f;

`ifdef SWITCH_DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYCLES);
  localparam logic [DBW-1:0] CNT_MAX = DBW'(DB_CYCLES - 1);

  logic [N_SW-1:0] cnt_zero;

  for (genvar i = 0; i < N_SW; i++) begin : g_db
    logic           f_bit;
    logic [DBW-1:0] cnt;

    // The counter runs only while s2 disagrees with the filtered bit; any
    // return to agreement clears it, so a glitch shorter than DB_CYCLES
    // cycles never reaches f and the next transition starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        f_bit <= 1'b0;
        cnt   <= '0;
      end else if (s2[i] == f_bit) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        f_bit <= s2[i];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign f[i]        = f_bit;
    assign cnt_zero[i] = (cnt == '0);
  end

  // Registered so it lines up with `lights`: both reflect the filter state
  // as it stood before the same clock edge.
  logic stable_next;
  assign stable_next = (&cnt_zero) && (s2 == f);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b1;
    end else begin
      stable <= stable_next;
    end
  end
`else
  assign f      = s2;
  assign stable = 1'b1;
`endif

  // Light code. The priority result is the last (highest) set index seen,
  // so the loop naturally keeps the top bit. Both results are at most
  // N_SW, which always fits in CNT_W bits.
  logic [CNT_W-1:0] pop_code;
  logic [CNT_W-1:0] pri_code;
  logic [CNT_W-1:0] lights_next;

  always_comb begin
    pop_code = '0;
    pri_code = '0;
    for (int i = 0; i < N_SW; i++) begin
      pop_code = pop_code + CNT_W'(f[i]);
      if (f[i]) begin
        pri_code = CNT_W'(i + 1);
      end
    end
    lights_next = mode ? pri_code : pop_code;
  end

  // `changed` compares against the current register, so a mode flip that
  // leaves the code unchanged produces no strobe, and several switches
  // accepted on one edge produce a single strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lights  <= '0;
      changed <= 1'b0;
    end else begin
      lights  <= lights_next;
      changed <= (lights_next != lights);
    end
  end

endmodule

// File: tb/tb_switch_lights_filtered.sv
// Testbench for switch_lights_filtered with N_SW=4, DB_CYCLES=4.
// Expected codes are pushed to exp_q when a stimulus is applied and popped
// on the edge where the light code is due to change. Latency expectations
// follow the build option: 7 edges with SWITCH_DEBOUNCE_EN, 3 without.
module tb_switch_lights_filtered;

  localparam int N_SW = 4;
  localparam int DB   = 4;
`ifdef SWITCH_DEBOUNCE_EN
  localparam int LAT  = DB + 3;
`else
  localparam int LAT  = 3;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] switches = 4'b0000;
  logic       mode = 1'b0;
  logic [2:0] lights;
  logic       changed;
  logic       stable;

  always #5 clk = ~clk;

  switch_lights_filtered #(
    .N_SW      (N_SW),
    .DB_CYCLES (DB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .switches (switches),
    .mode     (mode),
    .lights   (lights),
    .changed  (changed),
    .stable   (stable)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] cur_lights = 3'd0;

`ifndef SWITCH_DEBOUNCE_EN
  int stable_low = 0;
  always @(negedge clk) begin
    if (rst_n && stable !== 1'b1) stable_low++;
  end
`endif

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a switch pattern after an edge, then expect the new code exactly
  // LAT edges later, with a pulse only if the code differs, and no other
  // pulse within `hold` cycles.
  task automatic apply_and_check(input logic [3:0] sw, input logic [2:0] exp_code,
                                 input string name, input int hold);
    logic [2:0] e;
    int extra;
    extra = 0;
    switches = sw;
    exp_q.push_back(exp_code);
    for (int i = 1; i < LAT; i++) begin
      tick();
      if (changed === 1'b1) extra++;
    end
    checks++;
    if (lights !== cur_lights) begin
      errors++;
      $display("FAIL %s_early: lights=%0d expected %0d one edge before due", name, lights, cur_lights);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (lights !== e) begin
      errors++;
      $display("FAIL %s_code: lights=%0d expected %0d", name, lights, e);
    end
    checks++;
    if (changed !== (e != cur_lights)) begin
      errors++;
      $display("FAIL %s_pulse: changed=%b expected %b", name, changed, (e != cur_lights));
    end
    for (int i = LAT + 1; i <= hold; i++) begin
      tick();
      if (changed === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || lights !== e) begin
      errors++;
      $display("FAIL %s_hold: extra_pulses=%0d lights=%0d expected 0 and %0d", name, extra, lights, e);
    end
    cur_lights = e;
  endtask

  // Mode sampled on the next edge is reflected in lights right after it.
  task automatic apply_mode(input logic m, input logic [2:0] exp_code, input string name);
    logic [2:0] e;
    int extra;
    extra = 0;
    mode = m;
    exp_q.push_back(exp_code);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (lights !== e) begin
      errors++;
      $display("FAIL %s_code: lights=%0d expected %0d", name, lights, e);
    end
    checks++;
    if (changed !== (e != cur_lights)) begin
      errors++;
      $display("FAIL %s_pulse: changed=%b expected %b", name, changed, (e != cur_lights));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (changed === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL %s_extra: extra_pulses=%0d expected 0", name, extra);
    end
    cur_lights = e;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    switches = 4'b1111;
    mode = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (lights !== 3'd0 || changed !== 1'b0 || stable !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: lights=%0d changed=%b stable=%b expected 0 0 1", lights, changed, stable);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (lights !== 3'd0 || changed !== 1'b0 || stable !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold: lights=%0d changed=%b stable=%b expected 0 0 1", lights, changed, stable);
      end
    end
    rst_n = 1'b1;
    cur_lights = 3'd0;
    apply_and_check(4'b1111, 3'd4, "reset_release", 20);
  endtask

  task automatic test_popcount();
    logic [3:0] sw_tab [9] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd15};
    logic [2:0] ex_tab [9] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd2, 3'd2, 3'd3, 3'd1, 3'd4};
    mode = 1'b0;
    for (int i = 0; i < 9; i++) begin
      apply_and_check(sw_tab[i], ex_tab[i], $sformatf("popcount_%0d", sw_tab[i]), 20);
    end
  endtask

`ifdef SWITCH_DEBOUNCE_EN
  task automatic test_glitch();
    int pulses;
    int moved;
    bit saw_low;
    apply_and_check(4'b0000, 3'd0, "glitch_settle", 20);
    pulses = 0;
    moved = 0;
    saw_low = 1'b0;
    switches = 4'b0001;
    for (int i = 0; i < 18; i++) begin
      if (i == 3) switches = 4'b0000;
      tick();
      if (changed === 1'b1) pulses++;
      if (lights !== 3'd0) moved++;
      if (stable === 1'b0) saw_low = 1'b1;
    end
    checks++;
    if (moved != 0 || pulses != 0) begin
      errors++;
      $display("FAIL glitch_reject: lights_moved=%0d pulses=%0d expected 0 0", moved, pulses);
    end
    checks++;
    if (saw_low !== 1'b1) begin
      errors++;
      $display("FAIL glitch_stable_drop: stable_low_seen=%b expected 1", saw_low);
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL glitch_stable_return: stable=%b expected 1", stable);
    end
  endtask
`else
  task automatic test_no_filter();
    apply_and_check(4'b0000, 3'd0, "nofilter_zero", 20);
    apply_and_check(4'b1111, 3'd4, "nofilter_all", 20);
    checks++;
    if (stable_low != 0) begin
      errors++;
      $display("FAIL nofilter_stable: low_cycles=%0d expected 0", stable_low);
    end
  endtask
`endif

  task automatic test_priority();
    mode = 1'b0;
    apply_and_check(4'b0011, 3'd2, "prio_setup_0011", 20);
    apply_mode(1'b1, 3'd2, "mode_same_code");
    apply_mode(1'b0, 3'd2, "mode_back");
    apply_and_check(4'b0110, 3'd2, "pop_0110", 20);
    apply_mode(1'b1, 3'd3, "mode_new_code");
    apply_and_check(4'b1001, 3'd4, "prio_1001", 20);
    apply_and_check(4'b0001, 3'd1, "prio_0001", 20);
  endtask

  task automatic test_reset_mid_debounce();
    apply_and_check(4'b0000, 3'd0, "midrst_settle", 20);
    apply_mode(1'b0, 3'd0, "midrst_mode");
    switches = 4'b0001;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (lights !== 3'd0 || changed !== 1'b0 || stable !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async: lights=%0d changed=%b stable=%b expected 0 0 1", lights, changed, stable);
    end
    tick();
    tick();
    rst_n = 1'b1;
    cur_lights = 3'd0;
    apply_and_check(4'b0001, 3'd1, "midrst_release", 20);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_popcount();
`ifdef SWITCH_DEBOUNCE_EN
    test_glitch();
`else
    test_no_filter();
`endif
    test_priority();
    test_reset_mid_debounce();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
